// File: rtl/layer_sequencer_if.sv
// Handshake and control bundle between the dense-layer sequencer and its
// input buffer, weight ROM, MAC unit, result register file and phase machine.
interface layer_sequencer_if #(
  parameter int IN_W  = 2,
  parameter int NEU_W = 2
);
  logic                  start;
  logic [IN_W-1:0]       n_inputs;
  logic [NEU_W-1:0]      n_neurons;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_we;
  logic [IN_W-1:0]       in_addr;
  logic [NEU_W+IN_W-1:0] w_addr;
  logic                  mac_clr;
  logic                  mac_en;
  logic                  acc_store;
  logic [NEU_W-1:0]      neu_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic                  changes;
  logic                  finished;
  logic                  busy;
  logic [2:0]            state;

  modport master (
    input  start, n_inputs, n_neurons, in_valid, out_ready,
    output in_ready, in_we, in_addr, w_addr, mac_clr, mac_en, acc_store,
           neu_idx, out_valid, changes, finished, busy, state
  );

  modport slave (
    output start, n_inputs, n_neurons, in_valid, out_ready,
    input  in_ready, in_we, in_addr, w_addr, mac_clr, mac_en, acc_store,
           neu_idx, out_valid, changes, finished, busy, state
  );
endinterface

// File: rtl/layer_sequencer.sv
// Sequences one dense layer through a single shared MAC: load inputs, then
// per neuron clear/accumulate/store, then drain results downstream.
module layer_sequencer #(
  parameter int IN_W  = 2,
  parameter int NEU_W = 2
) (
  input logic              clk,
  input logic              reset,
  layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_CLEAR = 3'b010,
    S_MAC   = 3'b011,
    S_STORE = 3'b100,
    S_OUT   = 3'b101
  } state_t;

  typedef struct packed {
    logic [IN_W-1:0]  n_in;
    logic [NEU_W-1:0] n_neu;
  } cfg_t;

  state_t           state_q;
  cfg_t             cfg_q;
  logic [IN_W-1:0]  in_cnt;
  logic [NEU_W-1:0] neu_cnt;
  logic             in_ready_q, mac_clr_q, mac_en_q, acc_store_q;
  logic             out_valid_q, changes_q, finished_q, busy_q;
  logic             last_in, last_neu;

  // Comparing against the latched limits is what keeps the counters from wrapping.
  assign last_in  = (in_cnt == cfg_q.n_in);
  assign last_neu = (neu_cnt == cfg_q.n_neu);

  // Strobes are registered alongside the state transition into the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      in_cnt      <= '0;
      neu_cnt     <= '0;
      in_ready_q  <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      acc_store_q <= 1'b0;
      out_valid_q <= 1'b0;
      changes_q   <= 1'b0;
      finished_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      acc_store_q <= 1'b0;
      changes_q   <= 1'b0;
      finished_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            cfg_q.n_in  <= bus.n_inputs;
            cfg_q.n_neu <= bus.n_neurons;
            in_cnt      <= '0;
            neu_cnt     <= '0;
            state_q     <= S_LOAD;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            if (last_in) begin
              in_cnt     <= '0;
              neu_cnt    <= '0;
              state_q    <= S_CLEAR;
              in_ready_q <= 1'b0;
              mac_clr_q  <= 1'b1;
              changes_q  <= 1'b1;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        S_CLEAR: begin
          in_cnt   <= '0;
          state_q  <= S_MAC;
          mac_en_q <= 1'b1;
        end
        S_MAC: begin
          if (last_in) begin
            state_q     <= S_STORE;
            acc_store_q <= 1'b1;
          end else begin
            in_cnt   <= in_cnt + 1'b1;
            mac_en_q <= 1'b1;
          end
        end
        S_STORE: begin
          in_cnt <= '0;
          if (last_neu) begin
            neu_cnt     <= '0;
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
            changes_q   <= 1'b1;
          end else begin
            neu_cnt   <= neu_cnt + 1'b1;
            state_q   <= S_CLEAR;
            mac_clr_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (last_neu) begin
              neu_cnt     <= '0;
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              finished_q  <= 1'b1;
            end else begin
              neu_cnt <= neu_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_cnt      <= '0;
          neu_cnt     <= '0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.in_we     = bus.in_valid & in_ready_q;
  assign bus.in_addr   = in_cnt;
  assign bus.w_addr    = {neu_cnt, in_cnt};
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.acc_store = acc_store_q;
  assign bus.neu_idx   = neu_cnt;
  assign bus.out_valid = out_valid_q;
  assign bus.changes   = changes_q;
  assign bus.finished  = finished_q;
  assign bus.busy      = busy_q;
  assign bus.state     = state_q;

endmodule
